sync_fifo_wr_arb: RTL and testbench
===================================

# sync_fifo_wr_arb

Round-robin write-port arbiter that shares one `sync_fifo` write port among `N_REQ` producers. Each producer uses a valid/ready handshake. The arbiter grants one producer at a time for a bounded burst and forwards its beats to the FIFO. It honours FIFO `full` back-pressure, so no beat is ever dropped or duplicated. It sits directly in front of the FIFO's `wr_en_i`/`data_i`/`full_o` pins.

## Interface
- `N_REQ`, default 4: number of producers; at least 2.
- `DATA_W`, default 8: beat width; matches the FIFO data width.
- `MAX_BURST`, default 4: maximum beats accepted per grant; at least 1.
- `CNT_W`, default 16: width of each statistics counter (used only with the stats feature).
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid_i` in N_REQ: producer *i* has a beat.
- `req_data_i` in N_REQ*DATA_W: producer *i* data in bits [i*DATA_W +: DATA_W].
- `req_ready_o` out N_REQ: beat of producer *i* is accepted this cycle when valid and ready are both high.
- `grant_o` out N_REQ: one-hot current owner; all zero when idle.
- `busy_o` out 1: high when the state is BURST.
- `fifo_wr_en_o` out 1: drives the FIFO `wr_en_i`.
- `fifo_data_o` out DATA_W: drives the FIFO `data_i`.
- `fifo_full_i` in 1: from the FIFO `full_o`.
- `beat_cnt_o` out N_REQ*CNT_W: accepted-beat count per producer; present only when `SYNC_FIFO_ARB_STATS_EN` is defined.

## Operation
- **States** (`arb_state_e`): IDLE and BURST.
- **Registered state:** `state`, `grant_q` (index), `rr_ptr` (`$clog2(N_REQ)` bits), and `beat_cnt` (`$clog2(MAX_BURST+1)` bits).
- **Pick function:** choose the first asserted `req_valid_i` searching from `rr_ptr` upward. Wrap from N_REQ-1 to 0 by explicit compare, never by counter overflow.
- **IDLE:**
  - If any request is valid: latch the pick into `grant_q`, clear `beat_cnt`, go to BURST.
  - No `req_ready_o` is asserted while in IDLE.
- **BURST, ready and write rules:**
  - `req_ready_o[grant_q] = !fifo_full_i`; every other ready bit is 0.
  - `fifo_wr_en_o = req_valid_i[grant_q] && !fifo_full_i`.
  - `fifo_data_o` is the granted producer's data. It is a combinational mux, so zero latency from accept to FIFO write.
- **BURST, accepted beat:** increment `beat_cnt`.
- **BURST, release conditions** (checked each cycle):
  - An accepted beat brings `beat_cnt` to MAX_BURST, or
  - `req_valid_i[grant_q]` is low.
- **On release:**
  - Set `rr_ptr` to `grant_q+1` (wrapping).
  - Re-pick in the same cycle, searching from the new pointer and excluding a producer whose burst just completed.
  - If another producer is valid: stay in BURST with the new grant and `beat_cnt` cleared. There is no bubble.
  - If only the releasing producer is valid: regrant it.
  - If none are valid: go to IDLE.
- **FIFO full:**
  - Grant is held, `beat_cnt` holds, and no beat is accepted.
  - Full cycles do not count toward the burst.
  - Producers must hold valid and data stable until accepted.
- **Reset:**
  - Reset values: state=IDLE, `rr_ptr`=0, `grant_q`=0, `beat_cnt`=0, stats counters=0.
  - `req_ready_o` and `fifo_wr_en_o` are gated by `!rst`, so no write occurs during a reset cycle, including a reset that arrives mid-burst.

## Timing
- From IDLE, the earliest FIFO write is 1 cycle after valid is first sampled high.
- During BURST, throughput is 1 beat/cycle while the FIFO is not full.
- Switching grant at a release costs 0 cycles.
- `grant_o` and `busy_o` are registered-state decodes.
- `req_ready_o`, `fifo_wr_en_o` and `fifo_data_o` are combinational from state and `fifo_full_i`.
- Simultaneous FIFO read and arbiter write is handled by the FIFO. The arbiter only looks at `fifo_full_i`.

## Configuration
- **`SYNC_FIFO_ARB_STATS_EN` defined:**
  - Adds N_REQ counters of width CNT_W.
  - Counter *i* increments on each accepted beat of producer *i*.
  - Counters saturate at all-ones and reset to 0.
  - They drive `beat_cnt_o`.
- **Not defined:** the port `beat_cnt_o` and all counter logic are absent. Arbitration is identical.

## Structure
- **Package `sync_fifo_arb_pkg`:**
  - The `arb_state_e` enum (IDLE, BURST).
  - Default parameter constants.
  - A pointer-increment-with-wrap function.
- **Sub-module `rr_picker`:** combinational.
  - Inputs: request vector, start pointer, exclude mask.
  - Outputs: `found` and index.
  - It is instantiated once.

## Test plan
- **Single producer:** with N_REQ=4 and MAX_BURST=4, producer 2 is valid with 6 beats 0x10..0x15 and FIFO empty.
  - Required: writes 0x10..0x13, then a regrant to 2 with no bubble, then 0x14..0x15.
  - `rr_ptr` is 3 after the first burst.
- **All producers contending:** all four always valid.
  - Required: grants cycle 0,1,2,3,0; each grant is exactly 4 beats; no idle cycles between bursts.
- **FIFO full:** `fifo_full_i` is held high 3 cycles mid-burst after beat 2 of producer 1.
  - Required: no `fifo_wr_en_o` and no ready during those cycles; the grant stays on 1.
  - Beats 3 and 4 follow once full drops; no loss or duplication against the scoreboard.
- **Early release:** producer 0 drops valid after 1 beat while producer 3 is valid.
  - Required: the grant moves to 3 in the same cycle; `rr_ptr` becomes 1.
- **Reset mid-burst:** `rst` is asserted in the cycle a beat is valid and the FIFO is not full.
  - Required: `fifo_wr_en_o`=0 that cycle.
  - After reset: state IDLE, `grant_o`=0, and the next arbitration starts from producer 0.
- **Stats feature:** with the macro defined and CNT_W=4, 20 beats from producer 1.
  - Required: `beat_cnt_o[1]` saturates at 15; the other counters read 0.

Source files
------------

// File: rtl/sync_fifo_arb_pkg.sv
// Shared types and defaults for the round-robin FIFO write-port arbiter.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package sync_fifo_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_e;

    localparam int DEF_N_REQ     = 4;
    localparam int DEF_DATA_W    = 8;
    localparam int DEF_MAX_BURST = 4;
    localparam int DEF_CNT_W     = 16;

    // Wraps by explicit compare so non-power-of-two N_REQ never lands on a ghost index.
    function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned n);
        return (ptr == n - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/sync_fifo_wr_arb_picker.sv
// rr_picker: first asserted, non-excluded request searching upward from start.
// Latency: combinational.
// Backpressure: none; a pure function of its inputs.
module rr_picker #(
    parameter int N_REQ = 4,
    parameter int PTR_W = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PTR_W-1:0] start,
    input  logic [N_REQ-1:0] excl,
    output logic             found,
    output logic [PTR_W-1:0] idx
);

    always_comb begin
        int c;
        found = 1'b0;
        idx   = '0;
        c     = 0;
        for (int k = 0; k < N_REQ; k++) begin
            c = int'(start) + k;
            if (c >= N_REQ) begin
                c = c - N_REQ;
            end
            if (!found && req[c] && !excl[c]) begin
                found = 1'b1;
                idx   = PTR_W'(c);
            end
        end
    end

endmodule

// File: rtl/sync_fifo_wr_arb.sv
// Round-robin arbiter sharing one FIFO write port among N_REQ valid/ready producers; optional per-producer beat counters with SYNC_FIFO_ARB_STATS_EN.
// Latency: first write 1 cycle after valid is sampled in IDLE, then 1 beat/cycle with zero-cycle grant switches.
// Backpressure: fifo_full_i deasserts the granted ready and wr_en combinationally; the grant and burst count hold while full.
module sync_fifo_wr_arb
    import sync_fifo_arb_pkg::*;
#(
    parameter int N_REQ     = DEF_N_REQ,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int MAX_BURST = DEF_MAX_BURST
`ifdef SYNC_FIFO_ARB_STATS_EN
    ,
    parameter int CNT_W     = DEF_CNT_W
`endif
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req_valid_i,
    input  logic [N_REQ*DATA_W-1:0]  req_data_i,
    output logic [N_REQ-1:0]         req_ready_o,
    output logic [N_REQ-1:0]         grant_o,
    output logic                     busy_o,
    output logic                     fifo_wr_en_o,
    output logic [DATA_W-1:0]        fifo_data_o,
    input  logic                     fifo_full_i
`ifdef SYNC_FIFO_ARB_STATS_EN
    ,
    output logic [N_REQ*CNT_W-1:0]   beat_cnt_o
`endif
);

    localparam int PTR_W  = $clog2(N_REQ);
    localparam int BCNT_W = $clog2(MAX_BURST + 1);
    localparam logic [BCNT_W-1:0] LAST_BEAT = BCNT_W'(MAX_BURST - 1);

    arb_state_e        state, state_nxt;
    logic [PTR_W-1:0]  grant_q, grant_nxt;
    logic [PTR_W-1:0]  rr_ptr, rr_nxt;
    logic [BCNT_W-1:0] beat_cnt, bcnt_nxt;

    logic              busy;
    logic              gnt_valid;
    logic              accept;
    logic              burst_done;
    logic              release_now;
    logic [N_REQ-1:0]  gnt_onehot;
    logic [PTR_W-1:0]  ptr_next;

    logic [PTR_W-1:0]  pick_start;
    logic [N_REQ-1:0]  pick_excl;
    logic              pick_found;
    logic [PTR_W-1:0]  pick_idx;

    assign busy       = (state == BURST);
    assign gnt_valid  = req_valid_i[grant_q];
    assign gnt_onehot = N_REQ'(1) << grant_q;
    assign ptr_next   = PTR_W'(ptr_inc(32'(grant_q), N_REQ));

    // Reset gates the handshake so a reset landing mid-burst never writes.
    assign accept       = busy && gnt_valid && !fifo_full_i && !rst;
    assign req_ready_o  = (busy && !fifo_full_i && !rst) ? gnt_onehot : '0;
    assign fifo_wr_en_o = accept;
    assign fifo_data_o  = req_data_i[grant_q*DATA_W +: DATA_W];
    assign grant_o      = busy ? gnt_onehot : '0;
    assign busy_o       = busy;

    assign burst_done  = accept && (beat_cnt == LAST_BEAT);
    assign release_now = busy && (burst_done || !gnt_valid);

    // Idle arbitration searches from rr_ptr; a release re-picks from the slot after the owner.
    always_comb begin
        pick_start = rr_ptr;
        pick_excl  = '0;
        if (busy) begin
            pick_start = ptr_next;
            if (burst_done) begin
                pick_excl = gnt_onehot;
            end
        end
    end

    rr_picker #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_picker (
        .req   (req_valid_i),
        .start (pick_start),
        .excl  (pick_excl),
        .found (pick_found),
        .idx   (pick_idx)
    );

    always_comb begin
        state_nxt = state;
        grant_nxt = grant_q;
        rr_nxt    = rr_ptr;
        bcnt_nxt  = beat_cnt;
        case (state)
            IDLE: begin
                if (pick_found) begin
                    state_nxt = BURST;
                    grant_nxt = pick_idx;
                    bcnt_nxt  = '0;
                end
            end
            BURST: begin
                if (accept) begin
                    bcnt_nxt = beat_cnt + BCNT_W'(1);
                end
                if (release_now) begin
                    rr_nxt   = ptr_next;
                    bcnt_nxt = '0;
                    if (pick_found) begin
                        grant_nxt = pick_idx;
                    end else if (!gnt_valid) begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            grant_q  <= '0;
            rr_ptr   <= '0;
            beat_cnt <= '0;
        end else begin
            state    <= state_nxt;
            grant_q  <= grant_nxt;
            rr_ptr   <= rr_nxt;
            beat_cnt <= bcnt_nxt;
        end
    end

`ifdef SYNC_FIFO_ARB_STATS_EN
    logic [CNT_W-1:0] stat_q [N_REQ];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_REQ; i++) begin
                stat_q[i] <= '0;
            end
        end else if (accept && (stat_q[grant_q] != '1)) begin
            stat_q[grant_q] <= stat_q[grant_q] + CNT_W'(1);
        end
    end

    for (genvar g = 0; g < N_REQ; g++) begin : g_stat
        assign beat_cnt_o[g*CNT_W +: CNT_W] = stat_q[g];
    end
`endif

endmodule

// File: tb/tb_sync_fifo_wr_arb.sv
// Bench for sync_fifo_wr_arb: queue-backed producers, a per-cycle arbitration model and directed tables.
// Stats checks are compiled in only when SYNC_FIFO_ARB_STATS_EN is defined.
module tb_sync_fifo_wr_arb;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int MB = 4;
    localparam int CW = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [N-1:0]      req_valid_i = '0;
    logic [N*DW-1:0]   req_data_i = '0;
    logic [N-1:0]      req_ready_o;
    logic [N-1:0]      grant_o;
    logic              busy_o;
    logic              fifo_wr_en_o;
    logic [DW-1:0]     fifo_data_o;
    logic              fifo_full_i = 1'b0;
`ifdef SYNC_FIFO_ARB_STATS_EN
    logic [N*CW-1:0]   beat_cnt_o;
`endif

    sync_fifo_wr_arb #(
        .N_REQ     (N),
        .DATA_W    (DW),
        .MAX_BURST (MB)
`ifdef SYNC_FIFO_ARB_STATS_EN
        ,
        .CNT_W     (CW)
`endif
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid_i  (req_valid_i),
        .req_data_i   (req_data_i),
        .req_ready_o  (req_ready_o),
        .grant_o      (grant_o),
        .busy_o       (busy_o),
        .fifo_wr_en_o (fifo_wr_en_o),
        .fifo_data_o  (fifo_data_o),
        .fifo_full_i  (fifo_full_i)
`ifdef SYNC_FIFO_ARB_STATS_EN
        ,
        .beat_cnt_o   (beat_cnt_o)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Producer beats still waiting to be accepted, per producer.
    logic [DW-1:0] src_q [N][$];

    // Reference: owner index, busy flag, round-robin start, beats taken this grant.
    int m_busy = 0;
    int m_g    = 0;
    int m_ptr  = 0;
    int m_cnt  = 0;

    logic [N-1:0]  s_grant;
    logic [N-1:0]  s_ready;
    logic          s_wr;
    logic [DW-1:0] s_data;

    typedef struct {
        logic          full;
        logic [N-1:0]  grant;
        logic          wr;
        logic [DW-1:0] data;
    } vec_t;

    vec_t tbl [9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int first_from(input logic [N-1:0] v, input int start, input int skip);
        for (int k = 0; k < N; k++) begin
            int j;
            j = (start + k) % N;
            if (j != skip && v[j]) return j;
        end
        return -1;
    endfunction

    task automatic model_update(input logic [N-1:0] v, input logic full, input logic r);
        int p;
        logic acc, done;
        if (r) begin
            m_busy = 0; m_g = 0; m_ptr = 0; m_cnt = 0;
        end else if (m_busy == 0) begin
            p = first_from(v, m_ptr, -1);
            if (p >= 0) begin
                m_busy = 1; m_g = p; m_cnt = 0;
            end
        end else begin
            acc = v[m_g] && !full;
            if (acc) m_cnt++;
            done = acc && (m_cnt == MB);
            if (done || !v[m_g]) begin
                m_ptr = (m_g + 1) % N;
                m_cnt = 0;
                p = first_from(v, m_ptr, m_g);
                if (p >= 0) m_g = p;
                else if (!v[m_g]) m_busy = 0;
            end
        end
    endtask

    // One clock: drive at negedge, check against the model, pop accepted beats after posedge.
    task automatic step(input logic full, input logic r);
        logic [N-1:0] v, hs, eg;
        logic         ewr;
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            v[i] = (src_q[i].size() > 0);
            req_data_i[i*DW +: DW] = v[i] ? src_q[i][0] : '0;
        end
        req_valid_i = v;
        fifo_full_i = full;
        rst         = r;
        #1;
        s_grant = grant_o;
        s_ready = req_ready_o;
        s_wr    = fifo_wr_en_o;
        s_data  = fifo_data_o;
        eg  = (m_busy != 0) ? (N'(1) << m_g) : '0;
        ewr = !r && (m_busy != 0) && v[m_g] && !full;
        if (!r) begin
            chk("grant", grant_o, eg);
            chk("busy", busy_o, m_busy);
        end
        chk("ready", req_ready_o, (!r && !full) ? eg : '0);
        chk("wr_en", fifo_wr_en_o, ewr);
        if (ewr) chk("data", fifo_data_o, src_q[m_g][0]);
        hs = req_valid_i & req_ready_o;
        model_update(v, full, r);
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (hs[i]) void'(src_q[i].pop_front());
        end
    endtask

    task automatic do_reset();
        for (int i = 0; i < N; i++) src_q[i].delete();
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
    endtask

    function automatic int pending();
        int t;
        t = 0;
        for (int i = 0; i < N; i++) t += src_q[i].size();
        return t;
    endfunction

    task automatic drain();
        for (int k = 0; k < 300; k++) begin
            if (pending() == 0 && m_busy == 0) break;
            step(1'b0, 1'b0);
        end
        chk("drain_left", pending(), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state with no requests pending.
        do_reset();
        step(1'b0, 1'b0);
        chk("rst_grant", s_grant, 0);
        chk("rst_wr", s_wr, 0);
        chk("rst_ptr", dut.rr_ptr, 0);

        // Single producer 2, six beats: burst of 4, seamless regrant, then 2.
        tbl[0] = '{1'b0, 4'b0000, 1'b0, 8'h00};
        tbl[1] = '{1'b0, 4'b0100, 1'b1, 8'h10};
        tbl[2] = '{1'b0, 4'b0100, 1'b1, 8'h11};
        tbl[3] = '{1'b0, 4'b0100, 1'b1, 8'h12};
        tbl[4] = '{1'b0, 4'b0100, 1'b1, 8'h13};
        tbl[5] = '{1'b0, 4'b0100, 1'b1, 8'h14};
        tbl[6] = '{1'b0, 4'b0100, 1'b1, 8'h15};
        tbl[7] = '{1'b0, 4'b0100, 1'b0, 8'h00};
        tbl[8] = '{1'b0, 4'b0000, 1'b0, 8'h00};
        do_reset();
        for (int k = 0; k < 6; k++) src_q[2].push_back(8'(8'h10 + k));
        for (int k = 0; k < 9; k++) begin
            step(tbl[k].full, 1'b0);
            chk("tbl_grant", s_grant, tbl[k].grant);
            chk("tbl_wr", s_wr, tbl[k].wr);
            if (tbl[k].wr) chk("tbl_data", s_data, tbl[k].data);
            if (k == 5) chk("tbl_rr_ptr", dut.rr_ptr, 3);
        end

        // All four contending: 0,1,2,3,0 with four beats each and no gaps.
        do_reset();
        for (int i = 0; i < N; i++)
            for (int k = 0; k < 8; k++) src_q[i].push_back(8'((i << 4) | k));
        step(1'b0, 1'b0);
        for (int w = 0; w < 20; w++) begin
            step(1'b0, 1'b0);
            chk("rr_wr", s_wr, 1);
            chk("rr_grant", s_grant, 4'b0001 << ((w / 4) % 4));
        end
        drain();

        // FIFO full for three cycles after beat 2 of producer 1.
        do_reset();
        for (int k = 0; k < 4; k++) src_q[1].push_back(8'(8'h20 + k));
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        chk("full_b0", s_data, 8'h20);
        step(1'b0, 1'b0);
        chk("full_b1", s_data, 8'h21);
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 1'b0);
            chk("full_wr", s_wr, 0);
            chk("full_ready", s_ready, 0);
            chk("full_grant", s_grant, 4'b0010);
        end
        step(1'b0, 1'b0);
        chk("full_b2", s_data, 8'h22);
        step(1'b0, 1'b0);
        chk("full_b3", s_data, 8'h23);
        chk("full_left", src_q[1].size(), 0);
        drain();

        // Early release: producer 0 has one beat, producer 3 waiting.
        do_reset();
        src_q[0].push_back(8'h30);
        src_q[3].push_back(8'h40);
        src_q[3].push_back(8'h41);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        chk("early_g0", s_grant, 4'b0001);
        chk("early_d0", s_data, 8'h30);
        step(1'b0, 1'b0);
        chk("early_rel_wr", s_wr, 0);
        step(1'b0, 1'b0);
        chk("early_g3", s_grant, 4'b1000);
        chk("early_d3", s_data, 8'h40);
        chk("early_ptr", dut.rr_ptr, 1);
        drain();

        // Reset landing mid-burst, then arbitration restarts from producer 0.
        do_reset();
        for (int k = 0; k < 6; k++) src_q[1].push_back(8'(8'h50 + k));
        for (int k = 0; k < 6; k++) step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        chk("rstmid_wr", s_wr, 0);
        src_q[0].push_back(8'h60);
        step(1'b0, 1'b0);
        chk("rstmid_idle", s_grant, 0);
        step(1'b0, 1'b0);
        chk("rstmid_p0", s_grant, 4'b0001);
        drain();

        // Random traffic against the model, with occasional reset.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++)
                if (src_q[i].size() < 6 && $urandom_range(0, 3) == 0)
                    src_q[i].push_back(8'($urandom));
            step($urandom_range(0, 3) == 0, $urandom_range(0, 299) == 0);
        end
        drain();

`ifdef SYNC_FIFO_ARB_STATS_EN
        // Producer 1 counter saturates; others stay at zero.
        do_reset();
        for (int k = 0; k < 20; k++) src_q[1].push_back(8'(k));
        drain();
        chk("stat_p1", beat_cnt_o[1*CW +: CW], 15);
        chk("stat_p0", beat_cnt_o[0 +: CW], 0);
        chk("stat_p23", beat_cnt_o[2*CW +: 2*CW], 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
